// File: rtl/clock_time_controller.sv
// clock_time_controller
// Keeps hours/minutes/seconds from a 1 Hz tick pulse and runs the
// RUN -> SET_HR -> SET_MIN set-mode sequence driven by MODE/INC pulses.
// All state changes on the falling edge of CLK; CLEAR is async active-low.
//
// Handshake: TICK, MODE and INC are single-cycle strobes with no back-pressure.
// Each one is sampled exactly once, on the CLK falling edge where it is high.
// MODE outranks INC and TICK whenever they arrive in the same cycle.
module clock_time_controller #(
    parameter int HOURS   = 24,
    parameter int MINUTES = 60,
    parameter int SECONDS = 60
) (
    input  logic       CLK,
    input  logic       CLEAR,
    input  logic       TICK,
    input  logic       MODE,
    input  logic       INC,
    output logic [5:0] SEC,
    output logic [5:0] MIN,
    output logic [4:0] HR,
    output logic       SET_HR_ACT,
    output logic       SET_MIN_ACT,
    output logic       BLINK,
    output logic       DAY_CARRY
);

    localparam logic [5:0] SEC_MAX = 6'(SECONDS - 1);
    localparam logic [5:0] MIN_MAX = 6'(MINUTES - 1);
    localparam logic [4:0] HR_MAX  = 5'(HOURS - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hr_q, hr_d;
    logic       blink_q, blink_d;
    logic       day_carry_q, day_carry_d;
    logic       set_hr_q, set_min_q;

    // Next-state logic: mode sequencing, timekeeping and field editing.
    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hr_d        = hr_q;
        blink_d     = blink_q;
        day_carry_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (MODE) begin
                    // Entering SET_HR freezes SEC; a coincident tick is dropped.
                    state_d = ST_SET_HR;
                    blink_d = 1'b0;
                end else if (TICK) begin
                    blink_d = 1'b0;
                    if (sec_q == SEC_MAX) begin
                        sec_d = '0;
                        if (min_q == MIN_MAX) begin
                            min_d = '0;
                            if (hr_q == HR_MAX) begin
                                hr_d        = '0;
                                day_carry_d = 1'b1;
                            end else begin
                                hr_d = hr_q + 5'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end

            ST_SET_HR: begin
                if (MODE) begin
                    state_d = ST_SET_MIN;
                    blink_d = 1'b0;
                end else begin
                    if (TICK) begin
                        blink_d = ~blink_q;
                    end
                    if (INC) begin
                        hr_d = (hr_q == HR_MAX) ? 5'd0 : hr_q + 5'd1;
                    end
                end
            end

            ST_SET_MIN: begin
                if (MODE) begin
                    // Leaving set mode restarts the minute at second zero.
                    state_d = ST_RUN;
                    sec_d   = '0;
                    blink_d = 1'b0;
                end else begin
                    if (TICK) begin
                        blink_d = ~blink_q;
                    end
                    if (INC) begin
                        min_d = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    // State and output registers, falling-edge clocked with async clear.
    always_ff @(negedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q     <= ST_RUN;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            blink_q     <= 1'b0;
            day_carry_q <= 1'b0;
            set_hr_q    <= 1'b0;
            set_min_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            blink_q     <= blink_d;
            day_carry_q <= day_carry_d;
            set_hr_q    <= (state_d == ST_SET_HR);
            set_min_q   <= (state_d == ST_SET_MIN);
        end
    end

    assign SEC         = sec_q;
    assign MIN         = min_q;
    assign HR          = hr_q;
    assign BLINK       = blink_q;
    assign DAY_CARRY   = day_carry_q;
    assign SET_HR_ACT  = set_hr_q;
    assign SET_MIN_ACT = set_min_q;

endmodule

// File: tb/tb_clock_time_controller.sv
// tb_clock_time_controller
// Directed bench: inputs change and outputs are sampled 1 time unit after the
// falling (active) edge of CLK.
module tb_clock_time_controller;

  logic       CLK;
  logic       CLEAR;
  logic       TICK;
  logic       MODE;
  logic       INC;
  logic [5:0] SEC;
  logic [5:0] MIN;
  logic [4:0] HR;
  logic       SET_HR_ACT;
  logic       SET_MIN_ACT;
  logic       BLINK;
  logic       DAY_CARRY;

  int checks = 0;
  int errors = 0;

  clock_time_controller #(.HOURS(24), .MINUTES(60), .SECONDS(60)) dut (
    .CLK(CLK),
    .CLEAR(CLEAR),
    .TICK(TICK),
    .MODE(MODE),
    .INC(INC),
    .SEC(SEC),
    .MIN(MIN),
    .HR(HR),
    .SET_HR_ACT(SET_HR_ACT),
    .SET_MIN_ACT(SET_MIN_ACT),
    .BLINK(BLINK),
    .DAY_CARRY(DAY_CARRY)
  );

  // clock / reset
  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  // driver tasks
  task automatic cyc(input logic t, input logic m, input logic i);
    TICK = t;
    MODE = m;
    INC  = i;
    @(negedge CLK);
    #1;
    TICK = 1'b0;
    MODE = 1'b0;
    INC  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  // Called 1 unit after a falling edge: pulse CLEAR between edges, resync.
  task automatic do_reset();
    CLEAR = 1'b0;
    #3;
    CLEAR = 1'b1;
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLEAR = 1'b0;
    TICK  = 1'b0;
    MODE  = 1'b0;
    INC   = 1'b0;
    #2;
    checks++;
    if ({SEC, MIN, HR, SET_HR_ACT, SET_MIN_ACT, BLINK, DAY_CARRY} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state got sec=%0d min=%0d hr=%0d flags=%b%b%b%b want all 0",
               SEC, MIN, HR, SET_HR_ACT, SET_MIN_ACT, BLINK, DAY_CARRY);
    end
    #1;
    CLEAR = 1'b1;
    @(negedge CLK);
    #1;
  endtask

  task automatic test_seconds();
    do_reset();
    ticks(59);
    checks++;
    if ({SEC, MIN, HR} !== {6'd59, 6'd0, 5'd0}) begin
      errors++;
      $display("FAIL sec_59 got %0d:%0d:%0d want 0:0:59", HR, MIN, SEC);
    end
    ticks(1);
    checks++;
    if ({SEC, MIN, HR} !== {6'd0, 6'd1, 5'd0}) begin
      errors++;
      $display("FAIL sec_carry got %0d:%0d:%0d want 0:1:0", HR, MIN, SEC);
    end
  endtask

  task automatic test_day_wrap();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    incs(23);
    cyc(1'b0, 1'b1, 1'b0);
    incs(59);
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if ({SEC, MIN, HR, SET_HR_ACT, SET_MIN_ACT} !== {6'd0, 6'd59, 5'd23, 2'b00}) begin
      errors++;
      $display("FAIL preload got %0d:%0d:%0d act=%b%b want 23:59:0 act=00",
               HR, MIN, SEC, SET_HR_ACT, SET_MIN_ACT);
    end
    ticks(59);
    checks++;
    if ({SEC, MIN, HR, DAY_CARRY} !== {6'd59, 6'd59, 5'd23, 1'b0}) begin
      errors++;
      $display("FAIL pre_wrap got %0d:%0d:%0d dc=%b want 23:59:59 dc=0",
               HR, MIN, SEC, DAY_CARRY);
    end
    ticks(1);
    checks++;
    if ({SEC, MIN, HR, DAY_CARRY} !== {6'd0, 6'd0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL day_wrap got %0d:%0d:%0d dc=%b want 0:0:0 dc=1",
               HR, MIN, SEC, DAY_CARRY);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (DAY_CARRY !== 1'b0) begin
      errors++;
      $display("FAIL day_carry_width got dc=%b want 0", DAY_CARRY);
    end
  endtask

  task automatic test_set_sequence();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    incs(10);
    cyc(1'b0, 1'b1, 1'b0);
    incs(20);
    cyc(1'b0, 1'b1, 1'b0);
    ticks(35);
    checks++;
    if ({SEC, MIN, HR} !== {6'd35, 6'd20, 5'd10}) begin
      errors++;
      $display("FAIL time_10_20_35 got %0d:%0d:%0d want 10:20:35", HR, MIN, SEC);
    end
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if ({SET_HR_ACT, SET_MIN_ACT, BLINK, SEC} !== {3'b100, 6'd35}) begin
      errors++;
      $display("FAIL enter_set_hr got act=%b%b blink=%b sec=%0d want act=10 blink=0 sec=35",
               SET_HR_ACT, SET_MIN_ACT, BLINK, SEC);
    end
    incs(3);
    checks++;
    if (HR !== 5'd13) begin
      errors++;
      $display("FAIL hr_inc3 got hr=%0d want 13", HR);
    end
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if ({SET_HR_ACT, SET_MIN_ACT} !== 2'b01) begin
      errors++;
      $display("FAIL enter_set_min got act=%b%b want 01", SET_HR_ACT, SET_MIN_ACT);
    end
    incs(45);
    checks++;
    if ({MIN, HR} !== {6'd5, 5'd13}) begin
      errors++;
      $display("FAIL min_wrap got hr=%0d min=%0d want hr=13 min=5", HR, MIN);
    end
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if ({SEC, MIN, HR, SET_HR_ACT, SET_MIN_ACT, BLINK} !== {6'd0, 6'd5, 5'd13, 3'b000}) begin
      errors++;
      $display("FAIL exit_to_run got %0d:%0d:%0d act=%b%b blink=%b want 13:5:0 act=00 blink=0",
               HR, MIN, SEC, SET_HR_ACT, SET_MIN_ACT, BLINK);
    end
  endtask

  task automatic test_blink();
    logic [3:0] want_blink;
    want_blink = 4'b0101;
    do_reset();
    ticks(7);
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ticks(1);
      checks++;
      if ({BLINK, SEC, MIN, HR} !== {want_blink[k], 6'd7, 6'd0, 5'd0}) begin
        errors++;
        $display("FAIL blink_%0d got blink=%b time=%0d:%0d:%0d want blink=%b time=0:0:7",
                 k, BLINK, HR, MIN, SEC, want_blink[k]);
      end
    end
    incs(23);
    checks++;
    if (HR !== 5'd23) begin
      errors++;
      $display("FAIL hr_23 got hr=%0d want 23", HR);
    end
    incs(1);
    checks++;
    if ({HR, MIN, DAY_CARRY} !== {5'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL hr_set_wrap got hr=%0d min=%0d dc=%b want hr=0 min=0 dc=0", HR, MIN, DAY_CARRY);
    end
    cyc(1'b1, 1'b0, 1'b1);
    checks++;
    if ({HR, BLINK, SEC} !== {5'd1, 1'b1, 6'd7}) begin
      errors++;
      $display("FAIL tick_inc got hr=%0d blink=%b sec=%0d want hr=1 blink=1 sec=7", HR, BLINK, SEC);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    incs(5);
    cyc(1'b0, 1'b1, 1'b1);
    checks++;
    if ({SET_HR_ACT, SET_MIN_ACT, HR, MIN} !== {2'b01, 5'd5, 6'd0}) begin
      errors++;
      $display("FAIL mode_inc got act=%b%b hr=%0d min=%0d want act=01 hr=5 min=0",
               SET_HR_ACT, SET_MIN_ACT, HR, MIN);
    end
    cyc(1'b0, 1'b1, 1'b0);
    ticks(10);
    checks++;
    if (SEC !== 6'd10) begin
      errors++;
      $display("FAIL sec_10 got sec=%0d want 10", SEC);
    end
    cyc(1'b1, 1'b1, 1'b0);
    checks++;
    if ({SET_HR_ACT, SET_MIN_ACT, SEC, BLINK} !== {2'b10, 6'd10, 1'b0}) begin
      errors++;
      $display("FAIL mode_tick got act=%b%b sec=%0d blink=%b want act=10 sec=10 blink=0",
               SET_HR_ACT, SET_MIN_ACT, SEC, BLINK);
    end
  endtask

  task automatic test_async_clear();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    incs(30);
    ticks(1);
    checks++;
    if ({SET_MIN_ACT, MIN, BLINK} !== {1'b1, 6'd30, 1'b1}) begin
      errors++;
      $display("FAIL pre_clear got act_min=%b min=%0d blink=%b want 1 30 1", SET_MIN_ACT, MIN, BLINK);
    end
    CLEAR = 1'b0;
    #2;
    checks++;
    if ({SEC, MIN, HR, SET_HR_ACT, SET_MIN_ACT, BLINK, DAY_CARRY} !== 21'd0) begin
      errors++;
      $display("FAIL async_clear got sec=%0d min=%0d hr=%0d flags=%b%b%b%b want all 0",
               SEC, MIN, HR, SET_HR_ACT, SET_MIN_ACT, BLINK, DAY_CARRY);
    end
    #1;
    CLEAR = 1'b1;
    @(negedge CLK);
    #1;
    ticks(3);
    checks++;
    if ({SEC, MIN, HR, SET_HR_ACT, SET_MIN_ACT} !== {6'd3, 6'd0, 5'd0, 2'b00}) begin
      errors++;
      $display("FAIL resume_after_clear got %0d:%0d:%0d act=%b%b want 0:0:3 act=00",
               HR, MIN, SEC, SET_HR_ACT, SET_MIN_ACT);
    end
    cyc(1'b0, 1'b1, 1'b0);
    incs(4);
    CLEAR = 1'b0;
    #2;
    checks++;
    if ({SEC, MIN, HR, SET_HR_ACT, SET_MIN_ACT, BLINK} !== 20'd0) begin
      errors++;
      $display("FAIL async_clear_set_hr got sec=%0d min=%0d hr=%0d act=%b%b blink=%b want all 0",
               SEC, MIN, HR, SET_HR_ACT, SET_MIN_ACT, BLINK);
    end
    #1;
    CLEAR = 1'b1;
    @(negedge CLK);
    #1;
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_seconds();
    test_day_wrap();
    test_set_sequence();
    test_blink();
    test_simultaneous();
    test_async_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
